shared_reg_arbiter: RTL and testbench

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter_if.sv | 33 +++
 rtl/shared_reg_arbiter.sv | 85 ++++++++
 tb/tb_shared_reg_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the write requesters and the shared-register arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface shared_reg_arbiter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4
);
   localparam int unsigned IW = $clog2(N);

   logic [N-1:0]       req_valid;
   logic [N*WIDTH-1:0] req_data;
   logic [N-1:0]       req_ready;
   logic [WIDTH-1:0]   out;
   logic [IW-1:0]      grant_id;
   logic               busy;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  out,
      input  grant_id,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output out,
      output grant_id,
      output busy
   );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Shared register written by N requesters under round-robin arbitration.
// Every accepted write takes an IDLE->COMMIT pair; req_ready pulses in COMMIT.
module shared_reg_arbiter #(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   parameter int unsigned       N         = 4
) (
   input  logic               clk,
   input  logic               reset,
   shared_reg_arbiter_if.slave bus
);
   localparam int unsigned IW = $clog2(N);

   localparam logic IDLE   = 1'b0;
   localparam logic COMMIT = 1'b1;

   logic             state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    grant_q, grant_d;

   logic             found;
   logic [IW-1:0]    sel;
   logic [IW-1:0]    cand;

   // First valid requester scanning upward from ptr, wrapping N-1 to 0.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IW'((32'(ptr_q) + k) % N);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               data_d  = bus.req_data[32'(sel)*WIDTH +: WIDTH];
               grant_d = sel;
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= RESET_VAL;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (state_q == COMMIT) begin
         bus.req_ready[grant_q] = 1'b1;
      end
   end

   assign bus.busy     = (state_q == COMMIT);
   assign bus.out      = data_q;
   assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: expected grants are queued when a
// request pattern is driven and compared as each COMMIT cycle appears.
module tb_shared_reg_arbiter;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned N     = 4;
   localparam logic [WIDTH-1:0] RV = 8'd5;

   typedef struct {
      logic [1:0] gid;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic reset;
   logic [7:0] dv [N];
   exp_t sb [$];
   int   m_ptr;
   int   n_checks;
   int   n_pass;

   shared_reg_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

   shared_reg_arbiter #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RV),
      .N         (N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, want finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic set_data();
      bus.req_data = {dv[3], dv[2], dv[1], dv[0]};
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Drive a request pattern held for n grants; must be called at a negedge in IDLE.
   task automatic run(input logic [3:0] v, input int n);
      int g;
      int waited;
      exp_t e;
      bus.req_valid = v;
      for (int i = 0; i < n; i++) begin
         g = pick(v, m_ptr);
         e.gid  = 2'(g);
         e.data = dv[g];
         sb.push_back(e);
         m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < n; i++) begin
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (!bus.busy && waited < 4);
         check("latency", 32'(waited), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("grant_id", 32'(bus.grant_id), 32'(e.gid));
            check("out", 32'(bus.out), 32'(e.data));
            check("req_ready", 32'(bus.req_ready), 32'(4'b0001 << e.gid));
         end
         if (i == n - 1) bus.req_valid = '0;
         @(negedge clk);
         check("idle_busy", 32'(bus.busy), 32'd0);
         check("idle_ready", 32'(bus.req_ready), 32'd0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) dv[i] = '0;
      set_data();
      do_reset();
      @(negedge clk);
      check("rst_out", 32'(bus.out), 32'(RV));
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_grant", 32'(bus.grant_id), 32'd0);

      // Single write from requester 0.
      dv[0] = 8'hA5;
      set_data();
      run(4'b0001, 1);

      // Full contention from ptr 0: 0,1,2,3,0 with data i+1.
      do_reset();
      for (int i = 0; i < N; i++) dv[i] = 8'(i + 1);
      set_data();
      run(4'b1111, 5);

      // Grant 2 leaves ptr at 3; then 0101 wraps to 0 before 2.
      dv[0] = 8'h30;
      dv[2] = 8'h32;
      set_data();
      run(4'b0100, 1);
      run(4'b0101, 2);

      // Unselected data must not leak into the register.
      dv[0] = 8'h11;
      dv[1] = 8'hFF;
      set_data();
      run(4'b0011, 2);

      // Reset in COMMIT aborts the pulse and restores RESET_VAL.
      dv[1] = 8'h77;
      set_data();
      bus.req_valid = 4'b0010;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd1);
      check("abort_out", 32'(bus.out), 32'h77);
      reset = 1'b1;
      bus.req_valid = '0;
      @(negedge clk);
      check("abort_ready", 32'(bus.req_ready), 32'd0);
      check("abort_busyoff", 32'(bus.busy), 32'd0);
      check("abort_outrst", 32'(bus.out), 32'(RV));
      reset = 1'b0;
      m_ptr = 0;
      dv[2] = 8'h42;
      dv[3] = 8'h43;
      set_data();
      run(4'b1100, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
